// File: rtl/pov_column_sequencer_if.sv
// Handshake bundle between the POV column sequencer, the 77-bit string
// shift register and the LED bar driver.
interface pov_column_sequencer_if #(
  parameter int COL_BITS = 7,
  parameter int CIDX_W   = 4
) ();

  logic                sync_i;
  logic                ser_i;
  logic                init_o;
  logic                shift_o;
  logic [COL_BITS-1:0] led_o;
  logic [CIDX_W-1:0]   col_idx_o;
  logic                busy_o;
  logic                frame_done_o;
  logic                overrun_o;

  // Sequencer side: consumes the index pulse and shifter MSB, drives the rest.
  modport master (
    input  sync_i,
    input  ser_i,
    output init_o,
    output shift_o,
    output led_o,
    output col_idx_o,
    output busy_o,
    output frame_done_o,
    output overrun_o
  );

  // Environment side: shifter, index sync and LED driver.
  modport slave (
    output sync_i,
    output ser_i,
    input  init_o,
    input  shift_o,
    input  led_o,
    input  col_idx_o,
    input  busy_o,
    input  frame_done_o,
    input  overrun_o
  );

endinterface

// File: rtl/pov_column_sequencer.sv
// POV column sequencer: on each rotation index pulse, loads the string shift
// register once, then serially collects NUM_COLS columns of COL_BITS bits
// from its MSB and shows each column on the LED bar for HOLD_CYCLES clocks.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for sync_i; LEDs off, col_idx 0
// COLLECT | shifting one column in from ser_i, shift_o high each clock
// HOLD    | column displayed on led_o; hold counter running
module pov_column_sequencer #(
  parameter int COL_BITS    = 7,
  parameter int NUM_COLS    = 11,
  parameter int HOLD_CYCLES = 1000,
  parameter int CIDX_W      = 4
) (
  input logic                    clk,
  input logic                    rst,
  pov_column_sequencer_if.master bus
);

  localparam int BIT_W  = (COL_BITS > 1) ? $clog2(COL_BITS) : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

  state_t              state, state_nxt;
  logic [BIT_W-1:0]    bit_cnt, bit_cnt_nxt;
  logic [HOLD_W-1:0]   hold_cnt, hold_cnt_nxt;
  logic [CIDX_W-1:0]   col_idx, col_idx_nxt;
  logic [COL_BITS-1:0] col_sr, col_sr_nxt;
  logic [COL_BITS-1:0] led, led_nxt;
  logic                init, init_nxt;
  logic                shift, shift_nxt;
  logic                busy, busy_nxt;
  logic                frame_done, frame_done_nxt;
  logic                overrun, overrun_nxt;

  logic [COL_BITS-1:0] captured;
  logic                last_bit, hold_end, last_col;

  // State and every output/counter register; async reset clears all of them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      hold_cnt   <= '0;
      col_idx    <= '0;
      col_sr     <= '0;
      led        <= '0;
      init       <= 1'b0;
      shift      <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_nxt;
      bit_cnt    <= bit_cnt_nxt;
      hold_cnt   <= hold_cnt_nxt;
      col_idx    <= col_idx_nxt;
      col_sr     <= col_sr_nxt;
      led        <= led_nxt;
      init       <= init_nxt;
      shift      <= shift_nxt;
      busy       <= busy_nxt;
      frame_done <= frame_done_nxt;
      overrun    <= overrun_nxt;
    end
  end

  // Next-state and next-output logic; pulse outputs default low.
  always_comb begin
    state_nxt      = state;
    bit_cnt_nxt    = bit_cnt;
    hold_cnt_nxt   = hold_cnt;
    col_idx_nxt    = col_idx;
    col_sr_nxt     = col_sr;
    led_nxt        = led;
    init_nxt       = 1'b0;
    shift_nxt      = 1'b0;
    frame_done_nxt = 1'b0;
    overrun_nxt    = 1'b0;

    captured = {col_sr[COL_BITS-2:0], bus.ser_i};
    last_bit = (bit_cnt == BIT_W'(COL_BITS - 1));
    hold_end = (hold_cnt == HOLD_W'(HOLD_CYCLES - 1));
    last_col = (col_idx == CIDX_W'(NUM_COLS - 1));

    case (state)
      IDLE: begin
        led_nxt     = '0;
        col_idx_nxt = '0;
        if (bus.sync_i) begin
          init_nxt    = 1'b1;
          bit_cnt_nxt = '0;
          state_nxt   = COLLECT;
        end
      end

      COLLECT: begin
        col_sr_nxt = captured;
        // Stays high on the final capture so the next column's first bit
        // is already on ser_i when collection resumes.
        shift_nxt  = 1'b1;
        if (bus.sync_i) overrun_nxt = 1'b1;
        if (last_bit) begin
          led_nxt      = captured;
          hold_cnt_nxt = '0;
          state_nxt    = HOLD;
        end else begin
          bit_cnt_nxt = bit_cnt + 1'b1;
        end
      end

      HOLD: begin
        hold_cnt_nxt = hold_cnt + 1'b1;
        if (hold_end) begin
          led_nxt = '0;
          if (!last_col) begin
            col_idx_nxt = col_idx + 1'b1;
            bit_cnt_nxt = '0;
            state_nxt   = COLLECT;
            if (bus.sync_i) overrun_nxt = 1'b1;
          end else begin
            // A sync landing on the frame's final clock chains straight
            // into the next frame without being treated as an overrun.
            frame_done_nxt = 1'b1;
            col_idx_nxt    = '0;
            state_nxt      = IDLE;
            if (bus.sync_i) begin
              init_nxt    = 1'b1;
              bit_cnt_nxt = '0;
              state_nxt   = COLLECT;
            end
          end
        end else if (bus.sync_i) begin
          overrun_nxt = 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  assign bus.init_o       = init;
  assign bus.shift_o      = shift;
  assign bus.led_o        = led;
  assign bus.col_idx_o    = col_idx;
  assign bus.busy_o       = busy;
  assign bus.frame_done_o = frame_done;
  assign bus.overrun_o    = overrun;

endmodule

// File: tb/tb_pov_column_sequencer.sv
// Directed bench for pov_column_sequencer with a negedge model of the
// 77-bit string shift register and HOLD_CYCLES = 4 (11-clock columns).
module tb_pov_column_sequencer;

  localparam int COL_BITS    = 7;
  localparam int NUM_COLS    = 11;
  localparam int HOLD_CYCLES = 4;
  localparam int CIDX_W      = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [76:0] str   = '0;
  logic [76:0] regin = '0;

  int vectors    = 0;
  int miscompares = 0;

  pov_column_sequencer_if #(.COL_BITS(COL_BITS), .CIDX_W(CIDX_W)) bus ();

  pov_column_sequencer #(
    .COL_BITS   (COL_BITS),
    .NUM_COLS   (NUM_COLS),
    .HOLD_CYCLES(HOLD_CYCLES),
    .CIDX_W     (CIDX_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Shift register model: acts on init/shift at the falling edge.
  always @(negedge clk) begin
    if (bus.init_o)       regin <= str;
    else if (bus.shift_o) regin <= {regin[75:0], 1'b0};
  end
  assign bus.ser_i = regin[76];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One frame sampled every clock. t counts posedges after the one that
  // sampled sync. ovr_t: cycle in which a stray sync is driven (-1 none).
  // restart: drive sync on the final clock; started: frame already kicked off.
  task automatic run_frame(input logic [76:0] s, input int ovr_t,
                           input bit restart, input bit started);
    int          n_init, n_shift, c, ph;
    logic [6:0]  e_led;
    str = s;
    if (!started) begin
      bus.sync_i = 1'b1;
      step();
      bus.sync_i = 1'b0;
    end
    chk("init t=0", bus.init_o, 1);
    chk("busy t=0", bus.busy_o, 1);
    chk("led t=0", bus.led_o, 0);
    chk("cidx t=0", bus.col_idx_o, 0);
    chk("done t=0", bus.frame_done_o, started);
    n_init  = int'(bus.init_o);
    n_shift = int'(bus.shift_o);
    for (int t = 1; t <= 121; t++) begin
      bus.sync_i = (t - 1 == ovr_t) || (restart && t - 1 == 120);
      step();
      e_led = '0;
      if (t >= 7) begin
        c  = (t - 7) / 11;
        ph = (t - 7) % 11;
        if (ph < 4) e_led = s[76 - 7*c -: 7];
      end
      chk($sformatf("led t=%0d", t), bus.led_o, e_led);
      chk($sformatf("cidx t=%0d", t), bus.col_idx_o, (t == 121) ? 0 : t / 11);
      chk($sformatf("done t=%0d", t), bus.frame_done_o, t == 121);
      chk($sformatf("ovr t=%0d", t), bus.overrun_o, t == ovr_t + 1);
      chk($sformatf("busy t=%0d", t), bus.busy_o, (t < 121) || restart);
      chk($sformatf("init t=%0d", t), bus.init_o, (t == 121) && restart);
      chk($sformatf("shift t=%0d", t), bus.shift_o, (t < 121) && (((t - 1) % 11) < 7));
      if (t < 121) begin
        n_init  += int'(bus.init_o);
        n_shift += int'(bus.shift_o);
      end
    end
    bus.sync_i = 1'b0;
    chk("init count", n_init, 1);
    chk("shift count", n_shift, 77);
  endtask

  initial begin
    rst        = 1'b1;
    bus.sync_i = 1'b0;
    #2;
    chk("rst led", bus.led_o, 0);
    chk("rst init", bus.init_o, 0);
    chk("rst shift", bus.shift_o, 0);
    chk("rst busy", bus.busy_o, 0);
    chk("rst cidx", bus.col_idx_o, 0);
    chk("rst done", bus.frame_done_o, 0);
    chk("rst ovr", bus.overrun_o, 0);
    step();
    step();
    rst = 1'b0;
    step();
    chk("idle busy", bus.busy_o, 0);

    // Column 0 = 1010101, rest zero.
    run_frame({7'b1010101, 70'b0}, -1, 1'b0, 1'b0);
    step();
    chk("idle after f1", bus.busy_o, 0);

    // All ones.
    run_frame({77{1'b1}}, -1, 1'b0, 1'b0);
    step();

    // Stray sync during column 3 collection.
    run_frame({77{1'b1}}, 35, 1'b0, 1'b0);
    step();

    // Async reset in the middle of column 5 hold.
    str        = {77{1'b1}};
    bus.sync_i = 1'b1;
    step();
    bus.sync_i = 1'b0;
    for (int i = 0; i < 63; i++) step();
    chk("pre-rst led", bus.led_o, 7'h7F);
    chk("pre-rst cidx", bus.col_idx_o, 5);
    #2;
    rst = 1'b1;
    #1;
    chk("arst led", bus.led_o, 0);
    chk("arst shift", bus.shift_o, 0);
    chk("arst busy", bus.busy_o, 0);
    chk("arst cidx", bus.col_idx_o, 0);
    chk("arst init", bus.init_o, 0);
    step();
    step();
    rst = 1'b0;
    step();
    run_frame({77{1'b1}}, -1, 1'b0, 1'b0);
    step();

    // Sync on the frame_done clock chains into an identical second frame.
    run_frame(77'h1A_5F3C_9E07_B2D4_6C81, -1, 1'b1, 1'b0);
    run_frame(77'h1A_5F3C_9E07_B2D4_6C81, -1, 1'b0, 1'b1);
    step();
    chk("final idle", bus.busy_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
